// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT widths, twiddle constants and packed complex type
package fft_pkg;
  localparam int DEF_WIDTH = 26;
  localparam int DEF_FRAC  = 11;

  function automatic int half_width(input int width);
    return width / 2;
  endfunction

  localparam int DEF_HALF_WIDTH = half_width(DEF_WIDTH);

  typedef struct packed {
    logic signed [DEF_HALF_WIDTH-1:0] re;
    logic signed [DEF_HALF_WIDTH-1:0] im;
  } cplx_t;

  // Radix-4 twiddles in FRAC fixed point: 1, -j, -1
  localparam cplx_t W0_4 = '{re: DEF_HALF_WIDTH'(1 << DEF_FRAC), im: '0};
  localparam cplx_t W1_4 = '{re: '0, im: DEF_HALF_WIDTH'(-(1 << DEF_FRAC))};
  localparam cplx_t W2_4 = '{re: DEF_HALF_WIDTH'(-(1 << DEF_FRAC)), im: '0};
endpackage

// File: rtl/butterfly_4_pipe_if.sv
// rtl/butterfly_4_pipe_if.sv - sample/twiddle input and DFT output handshake bundle
interface butterfly_4_pipe_if #(
  parameter int WIDTH = fft_pkg::DEF_WIDTH
) ();
  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic [WIDTH-1:0] a, b, c, d;
  logic [WIDTH-1:0] w0, w1, w2, w3;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic [WIDTH-1:0] out0, out1, out2, out3;
  logic             ovf;

  modport master (
    output in_valid, in_last, a, b, c, d, w0, w1, w2, w3, out_ready,
    input  in_ready, out_valid, out_last, out0, out1, out2, out3, ovf
  );

  modport slave (
    input  in_valid, in_last, a, b, c, d, w0, w1, w2, w3, out_ready,
    output in_ready, out_valid, out_last, out0, out1, out2, out3, ovf
  );
endinterface

// File: rtl/complex_mult.sv
// rtl/complex_mult.sv - complex sample x twiddle product, round-half-up to HALF_WIDTH+1 bits
module complex_mult
  import fft_pkg::*;
#(
  parameter int HALF_WIDTH = DEF_HALF_WIDTH,
  parameter int FRAC       = DEF_FRAC
) (
  input  logic signed [HALF_WIDTH-1:0] i_x_re,
  input  logic signed [HALF_WIDTH-1:0] i_x_im,
  input  logic signed [HALF_WIDTH-1:0] i_w_re,
  input  logic signed [HALF_WIDTH-1:0] i_w_im,
  output logic signed [HALF_WIDTH:0]   o_p_re,
  output logic signed [HALF_WIDTH:0]   o_p_im
);
  localparam int PW = 2 * HALF_WIDTH + 1;
  localparam logic signed [PW-1:0] RND = PW'(1 << (FRAC - 1));

  logic signed [PW-1:0] w_re_rnd;
  logic signed [PW-1:0] w_im_rnd;
  logic                 w_unused;

  assign w_re_rnd = PW'(i_x_re) * PW'(i_w_re) - PW'(i_x_im) * PW'(i_w_im) + RND;
  assign w_im_rnd = PW'(i_x_re) * PW'(i_w_im) + PW'(i_x_im) * PW'(i_w_re) + RND;

  // Slicing above FRAC is the arithmetic shift; the top bits are dropped by design
  assign o_p_re = w_re_rnd[FRAC +: HALF_WIDTH+1];
  assign o_p_im = w_im_rnd[FRAC +: HALF_WIDTH+1];

  assign w_unused = ^{w_re_rnd[FRAC-1:0], w_re_rnd[PW-1:FRAC+HALF_WIDTH+1],
                      w_im_rnd[FRAC-1:0], w_im_rnd[PW-1:FRAC+HALF_WIDTH+1]};
endmodule

// File: rtl/butterfly_4_pipe.sv
// rtl/butterfly_4_pipe.sv - 3-stage radix-4 DIT butterfly with twiddle multiply and sticky overflow
// BUTTERFLY_SCALE_EN: when defined, outputs are divided by 4 before narrowing.
module butterfly_4_pipe
  import fft_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC
) (
  input  logic               i_clk,
  input  logic               i_rst,
  butterfly_4_pipe_if.slave  bus
);
  localparam int HW = half_width(WIDTH);
  localparam int BW = HW + 3;

  logic                 w_en;
  logic [WIDTH-1:0]     w_x [4];
  logic [WIDTH-1:0]     w_w [4];
  logic signed [HW:0]   w_p_re [4];
  logic signed [HW:0]   w_p_im [4];
  logic signed [BW-1:0] w_pe_re [4];
  logic signed [BW-1:0] w_pe_im [4];
  logic signed [BW-1:0] w_xr [4];
  logic signed [BW-1:0] w_xi [4];
  logic signed [BW-1:0] w_nr [4];
  logic signed [BW-1:0] w_ni [4];
  logic [WIDTH-1:0]     w_out [4];
  logic [3:0]           w_ovf_k;

  logic                 r_v1, r_v2, r_v3;
  logic                 r_l1, r_l2, r_l3;
  logic signed [HW:0]   r_p_re [4];
  logic signed [HW:0]   r_p_im [4];
  logic signed [BW-1:0] r_sp_re [2];
  logic signed [BW-1:0] r_sp_im [2];
  logic signed [BW-1:0] r_sm_re [2];
  logic signed [BW-1:0] r_sm_im [2];
  logic [WIDTH-1:0]     r_out [4];
  logic                 r_ovf;

  // Whole pipeline advances together; stalls only when S3 is held by the consumer
  assign w_en         = !r_v3 || bus.out_ready;
  assign bus.in_ready = w_en;

  assign w_x[0] = bus.a;   assign w_x[1] = bus.b;
  assign w_x[2] = bus.c;   assign w_x[3] = bus.d;
  assign w_w[0] = bus.w0;  assign w_w[1] = bus.w1;
  assign w_w[2] = bus.w2;  assign w_w[3] = bus.w3;

  genvar k;
  generate
    for (k = 0; k < 4; k++) begin : g_lane
      complex_mult #(.HALF_WIDTH(HW), .FRAC(FRAC)) u_mult (
        .i_x_re (w_x[k][WIDTH-1:HW]),
        .i_x_im (w_x[k][HW-1:0]),
        .i_w_re (w_w[k][WIDTH-1:HW]),
        .i_w_im (w_w[k][HW-1:0]),
        .o_p_re (w_p_re[k]),
        .o_p_im (w_p_im[k])
      );
      assign w_pe_re[k] = {{2{r_p_re[k][HW]}}, r_p_re[k]};
      assign w_pe_im[k] = {{2{r_p_im[k][HW]}}, r_p_im[k]};
`ifdef BUTTERFLY_SCALE_EN
      assign w_nr[k] = w_xr[k] >>> 2;
      assign w_ni[k] = w_xi[k] >>> 2;
`else
      assign w_nr[k] = w_xr[k];
      assign w_ni[k] = w_xi[k];
`endif
      assign w_ovf_k[k] = (w_nr[k][BW-1:HW-1] != {(BW-HW+1){w_nr[k][HW-1]}}) ||
                          (w_ni[k][BW-1:HW-1] != {(BW-HW+1){w_ni[k][HW-1]}});
      assign w_out[k] = {w_nr[k][HW-1:0], w_ni[k][HW-1:0]};
    end
  endgenerate

  // -j*(r + j i) = i - j r ; +j*(r + j i) = -i + j r
  assign w_xr[0] = r_sp_re[0] + r_sp_re[1];
  assign w_xi[0] = r_sp_im[0] + r_sp_im[1];
  assign w_xr[1] = r_sm_re[0] + r_sm_im[1];
  assign w_xi[1] = r_sm_im[0] - r_sm_re[1];
  assign w_xr[2] = r_sp_re[0] - r_sp_re[1];
  assign w_xi[2] = r_sp_im[0] - r_sp_im[1];
  assign w_xr[3] = r_sm_re[0] - r_sm_im[1];
  assign w_xi[3] = r_sm_im[0] + r_sm_re[1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_v3  <= 1'b0;
      r_l1  <= 1'b0;
      r_l2  <= 1'b0;
      r_l3  <= 1'b0;
      r_ovf <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_p_re[i] <= '0;
        r_p_im[i] <= '0;
        r_out[i]  <= '0;
      end
      for (int i = 0; i < 2; i++) begin
        r_sp_re[i] <= '0;
        r_sp_im[i] <= '0;
        r_sm_re[i] <= '0;
        r_sm_im[i] <= '0;
      end
    end else if (w_en) begin
      r_v1 <= bus.in_valid;
      r_l1 <= bus.in_last;
      for (int i = 0; i < 4; i++) begin
        r_p_re[i] <= w_p_re[i];
        r_p_im[i] <= w_p_im[i];
      end
      r_v2 <= r_v1;
      r_l2 <= r_l1;
      for (int i = 0; i < 2; i++) begin
        r_sp_re[i] <= w_pe_re[i] + w_pe_re[i+2];
        r_sp_im[i] <= w_pe_im[i] + w_pe_im[i+2];
        r_sm_re[i] <= w_pe_re[i] - w_pe_re[i+2];
        r_sm_im[i] <= w_pe_im[i] - w_pe_im[i+2];
      end
      r_v3 <= r_v2;
      r_l3 <= r_l2;
      for (int i = 0; i < 4; i++) begin
        r_out[i] <= w_out[i];
      end
      if (r_v2 && (|w_ovf_k)) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign bus.out_valid = r_v3;
  assign bus.out_last  = r_l3;
  assign bus.out0      = r_out[0];
  assign bus.out1      = r_out[1];
  assign bus.out2      = r_out[2];
  assign bus.out3      = r_out[3];
  assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_butterfly_4_pipe.sv
// tb/tb_butterfly_4_pipe.sv - directed and randomized checks of butterfly_4_pipe against a DFT model
module tb_butterfly_4_pipe;
  import fft_pkg::*;

  localparam int WIDTH = 26;
  localparam int HW    = 13;
  localparam int FRAC  = 11;
`ifdef BUTTERFLY_SCALE_EN
  localparam bit SCALE = 1'b1;
`else
  localparam bit SCALE = 1'b0;
`endif

  typedef struct {
    logic [WIDTH-1:0] x [4];
    logic [WIDTH-1:0] w [4];
    logic             last;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] o [4];
    logic             last;
    logic             ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  butterfly_4_pipe_if #(.WIDTH(WIDTH)) bus ();
  butterfly_4_pipe #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int   total = 0;
  int   bad   = 0;
  int   n_out = 0;
  exp_t exp_q [$];
  vec_t sq [$];
  logic m_ovf = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, want);
    end
  endtask

  function automatic logic [WIDTH-1:0] pk(input longint re, input longint im);
    return {re[HW-1:0], im[HW-1:0]};
  endfunction

  function automatic longint re_of(input logic [WIDTH-1:0] v);
    logic signed [HW-1:0] t;
    t = v[WIDTH-1:HW];
    return longint'(t);
  endfunction

  function automatic longint im_of(input logic [WIDTH-1:0] v);
    logic signed [HW-1:0] t;
    t = v[HW-1:0];
    return longint'(t);
  endfunction

  function automatic longint wrap(input longint v, input int bits);
    longint m, r;
    m = longint'(1) << bits;
    r = v & (m - 1);
    if (r >= m / 2) r = r - m;
    return r;
  endfunction

  // X_k = sum_n p_n * (-j)^(n*k), p_n = round(x_n * w_n) kept at HW+1 bits
  function automatic exp_t model(input vec_t v);
    exp_t   e;
    longint pr [4];
    longint pi [4];
    longint xr, xi, wr, wi, sr, si, tr, ti;
    for (int n = 0; n < 4; n++) begin
      xr = re_of(v.x[n]); xi = im_of(v.x[n]);
      wr = re_of(v.w[n]); wi = im_of(v.w[n]);
      pr[n] = wrap((xr * wr - xi * wi + (1 << (FRAC - 1))) >>> FRAC, HW + 1);
      pi[n] = wrap((xr * wi + xi * wr + (1 << (FRAC - 1))) >>> FRAC, HW + 1);
    end
    e.ovf  = 1'b0;
    e.last = v.last;
    for (int kk = 0; kk < 4; kk++) begin
      sr = 0; si = 0;
      for (int n = 0; n < 4; n++) begin
        case ((n * kk) % 4)
          0:       begin tr =  pr[n]; ti =  pi[n]; end
          1:       begin tr =  pi[n]; ti = -pr[n]; end
          2:       begin tr = -pr[n]; ti = -pi[n]; end
          default: begin tr = -pi[n]; ti =  pr[n]; end
        endcase
        sr += tr; si += ti;
      end
      if (SCALE) begin
        sr = sr >>> 2;
        si = si >>> 2;
      end
      if (wrap(sr, HW) != sr || wrap(si, HW) != si) e.ovf = 1'b1;
      e.o[kk] = pk(sr, si);
    end
    return e;
  endfunction

  task automatic drive(input vec_t v);
    bus.a  = v.x[0]; bus.b  = v.x[1]; bus.c  = v.x[2]; bus.d  = v.x[3];
    bus.w0 = v.w[0]; bus.w1 = v.w[1]; bus.w2 = v.w[2]; bus.w3 = v.w[3];
    bus.in_last = v.last;
  endtask

  function automatic vec_t unit_vec();
    vec_t v;
    for (int n = 0; n < 4; n++) begin
      v.x[n] = '0;
      v.w[n] = W0_4;
    end
    v.last = 1'b0;
    return v;
  endfunction

  function automatic vec_t small_vec(input logic last);
    vec_t v;
    v = unit_vec();
    for (int n = 0; n < 4; n++)
      v.x[n] = pk(longint'($urandom_range(0, 1000)) - 500, longint'($urandom_range(0, 1000)) - 500);
    v.last = last;
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int n = 0; n < 4; n++) begin
      v.x[n] = WIDTH'($urandom);
      v.w[n] = pk(longint'($urandom_range(0, 4096)) - 2048, longint'($urandom_range(0, 4096)) - 2048);
    end
    v.last = 1'($urandom);
    return v;
  endfunction

  // Single compare process: model queue fed by accepted inputs, drained by output handshakes
  logic [WIDTH-1:0] s_out [4];
  logic             s_last;
  logic             stall_prev = 1'b0;

  always @(negedge clk) begin : mon
    exp_t             e;
    vec_t             cv;
    logic [WIDTH-1:0] cur [4];
    cur[0] = bus.out0; cur[1] = bus.out1; cur[2] = bus.out2; cur[3] = bus.out3;
    if (rst) begin
      exp_q.delete();
      m_ovf      = 1'b0;
      stall_prev = 1'b0;
    end else begin
      chk("in_ready_rule", bus.in_ready, !bus.out_valid || bus.out_ready);
      chk("ovf_track", bus.ovf,
          m_ovf | ((bus.out_valid && exp_q.size() > 0) ? exp_q[0].ovf : 1'b0));
      if (stall_prev) begin
        chk("stall_valid", bus.out_valid, 1'b1);
        chk("stall_last", bus.out_last, s_last);
        for (int n = 0; n < 4; n++) chk("stall_data", cur[n], s_out[n]);
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("expected_pending", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          m_ovf = m_ovf | e.ovf;
          for (int n = 0; n < 4; n++) chk("model_out", cur[n], e.o[n]);
          chk("model_last", bus.out_last, e.last);
          n_out++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        cv.x[0] = bus.a;  cv.x[1] = bus.b;  cv.x[2] = bus.c;  cv.x[3] = bus.d;
        cv.w[0] = bus.w0; cv.w[1] = bus.w1; cv.w[2] = bus.w2; cv.w[3] = bus.w3;
        cv.last = bus.in_last;
        exp_q.push_back(model(cv));
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      s_last = bus.out_last;
      for (int n = 0; n < 4; n++) s_out[n] = cur[n];
    end
  end

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic send_one(input vec_t v, output int lat);
    drive(v);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic stream(input int stall_from, input int stall_len, output logic saw_low);
    int   sent, c;
    logic acc;
    sent = 0; c = 0; saw_low = 1'b0;
    while ((sent < sq.size() || c < stall_from + stall_len) && c < 200) begin
      bus.out_ready = !(c >= stall_from && c < stall_from + stall_len);
      if (sent < sq.size()) begin
        drive(sq[sent]);
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #2;
      acc = bus.in_valid && bus.in_ready;
      if (!bus.in_ready) saw_low = 1'b1;
      @(posedge clk); #1;
      if (acc) sent++;
      c++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("stream_all_sent", sent, sq.size());
  endtask

  initial begin : main
    vec_t v;
    int   lat, n0;
    logic low, acc, hold;

    rst = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    drive(unit_vec());
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out0", bus.out0, '0);
    chk("rst_out1", bus.out1, '0);
    chk("rst_out2", bus.out2, '0);
    chk("rst_out3", bus.out3, '0);
    chk("rst_out_last", bus.out_last, 1'b0);
    chk("rst_ovf", bus.ovf, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    rst = 1'b0;
    idle(1);

    // Real ramp, unity twiddles
    v = unit_vec();
    v.x[0] = pk(100, 0); v.x[1] = pk(150, 0); v.x[2] = pk(200, 0); v.x[3] = pk(250, 0);
    v.last = 1'b1;
    send_one(v, lat);
    chk("ramp_latency", lat, 3);
    chk("ramp_out0", bus.out0, SCALE ? pk(175, 0)   : pk(700, 0));
    chk("ramp_out1", bus.out1, SCALE ? pk(-25, 25)  : pk(-100, 100));
    chk("ramp_out2", bus.out2, SCALE ? pk(-25, 0)   : pk(-100, 0));
    chk("ramp_out3", bus.out3, SCALE ? pk(-25, -25) : pk(-100, -100));
    chk("ramp_last", bus.out_last, 1'b1);
    chk("ramp_ovf", bus.ovf, 1'b0);
    idle(3);

    // -j twiddle on b
    v = unit_vec();
    v.x[1] = pk(100, 0);
    v.w[1] = W1_4;
    send_one(v, lat);
    chk("rot_latency", lat, 3);
    chk("rot_out0", bus.out0, SCALE ? pk(0, -25) : pk(0, -100));
    chk("rot_out1", bus.out1, SCALE ? pk(-25, 0) : pk(-100, 0));
    chk("rot_out2", bus.out2, SCALE ? pk(0, 25)  : pk(0, 100));
    chk("rot_out3", bus.out3, SCALE ? pk(25, 0)  : pk(100, 0));
    idle(3);

    // 1 * 0.5 rounds half up to 1
    v = unit_vec();
    v.x[0] = pk(1, 0);
    v.w[0] = pk(1024, 0);
    send_one(v, lat);
    chk("half_out0", bus.out0, SCALE ? pk(0, 0) : pk(1, 0));
    chk("half_out3", bus.out3, SCALE ? pk(0, 0) : pk(1, 0));
    idle(3);

    // Overflow then sticky across clean traffic
    v = unit_vec();
    for (int n = 0; n < 4; n++) v.x[n] = pk(4000, 0);
    send_one(v, lat);
    chk("ovf_out0", bus.out0, SCALE ? pk(4000, 0) : pk(-384, 0));
    chk("ovf_flag", bus.ovf, !SCALE);
    idle(2);
    sq.delete();
    for (int i = 0; i < 10; i++) sq.push_back(small_vec(1'b0));
    stream(-1, 0, low);
    idle(5);
    chk("ovf_sticky", bus.ovf, !SCALE);
    pulse_rst();
    chk("ovf_cleared", bus.ovf, 1'b0);
    idle(1);

    // Backpressure: 5 vectors, consumer stalls cycles 2..7
    sq.delete();
    for (int i = 0; i < 5; i++) sq.push_back(small_vec(i == 2));
    n0 = n_out;
    stream(2, 6, low);
    idle(8);
    chk("bp_in_ready_dropped", low, 1'b1);
    chk("bp_out_count", n_out - n0, 5);
    chk("bp_drained", exp_q.size(), 0);

    // Reset with three vectors in flight and a vector offered during reset
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(small_vec(1'b1));
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    drive(small_vec(1'b1));
    @(posedge clk); #1;
    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("mid_rst_valid", bus.out_valid, 1'b0);
    chk("mid_rst_out0", bus.out0, '0);
    chk("mid_rst_out3", bus.out3, '0);
    chk("mid_rst_last", bus.out_last, 1'b0);
    n0 = n_out;
    idle(6);
    chk("mid_rst_no_output", n_out - n0, 0);
    send_one(small_vec(1'b0), lat);
    chk("post_rst_latency", lat, 3);
    idle(3);
    chk("post_rst_count", n_out - n0, 1);

    // Random traffic with random backpressure, full-range data and twiddles
    hold = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!hold) begin
        drive(rand_vec());
        bus.in_valid = ($urandom % 4) != 0;
      end
      bus.out_ready = ($urandom % 4) != 0;
      #2;
      acc  = bus.in_valid && bus.in_ready;
      hold = bus.in_valid && !acc;
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    idle(8);
    chk("rand_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
